cosim_commit_serializer: RTL and testbench
==========================================

COSIM_COMMIT_SERIALIZER -- requirements
Module: cosim_commit_serializer

Interface
REQ-001 SHALL have parameters: COMMIT_WIDTH, default 2, commit lanes per cycle; XLEN, default 64, data width; INST_BITS, default 32, instruction width; RD, default 5, register-index width; HARTID_LEN, default 1, hart-id width; DEPTH, default 8, buffer entries (power of two, >= COMMIT_WIDTH+1).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clock  input  1  sole clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- hartid  input  HARTID_LEN  static hart id; forwarded to out_hartid
- valid, check, wdata_valid, insn_writes_back  input  COMMIT_WIDTH  per-lane commit flags
- pc, wdata, mstatus  input  XLEN*COMMIT_WIDTH  per-lane fields; lane i at bits [(i+1)*XLEN-1 -: XLEN]
- inst  input  INST_BITS*COMMIT_WIDTH  per-lane instruction
- wdata_dest, insn_wdata_dest  input  RD*COMMIT_WIDTH  per-lane destination
- int_xcpt  input  1  interrupt/exception raised this cycle
- cause  input  XLEN  trap cause
- out_valid  output  1  entry available
- out_ready  input  1  consumer accepts entry
- out_is_trap  output  1  entry is a trap, not a commit
- out_pc, out_wdata, out_mstatus, out_cause  output  XLEN  entry fields
- out_inst  output  INST_BITS; out_wdata_dest, out_insn_wdata_dest  output  RD
- out_check, out_wdata_valid, out_insn_writes_back  output  1 each
- out_hartid  output  HARTID_LEN
- count  output  $clog2(DEPTH+1)  current occupancy
- overflow  output  1  sticky: a cycle's group was dropped
- drop_count  output  16  dropped groups, saturating at 16'hFFFF

Function
REQ-003 Each cycle SHALL form a group: valid lanes in ascending lane order (compacted, no holes), then one trap entry if int_xcpt=1; group size n = popcount(valid)+int_xcpt, 0..COMMIT_WIDTH+1.
REQ-004 A trap entry SHALL carry is_trap=1, cause, all other fields zero; commit entries SHALL carry is_trap=0, cause zero.
REQ-005 Group SHALL be accepted whole iff n <= DEPTH-count, where count is the pre-edge occupancy (a same-cycle pop does not free space).
REQ-006 Rejected group (n>0, insufficient space) SHALL be dropped entirely, set overflow, increment drop_count (saturating); no partial writes.
REQ-007 out_valid SHALL equal (count != 0); out_* fields SHALL reflect the head entry, driven from storage (no combinational input-to-output path).
REQ-008 Pop SHALL occur when out_valid && out_ready; at most one pop per cycle.
REQ-009 Latency: entry accepted at edge N SHALL be visible at head no earlier than after edge N (i.e. out_valid the cycle after push into empty buffer).
REQ-010 count SHALL update as count + n_accepted - pop every edge; simultaneous push and pop legal.
REQ-011 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; a group may straddle the wrap point.
REQ-012 Head fields SHALL be stable while out_valid && !out_ready.
REQ-013 out_hartid SHALL equal hartid combinationally.

Reset
REQ-014 On reset low, immediately: pointers=0, count=0, out_valid=0, overflow=0, drop_count=0; storage contents need not reset; out_* data fields are don't-care while out_valid=0.
REQ-015 Reset asserted mid-operation SHALL discard all buffered entries; no group is accepted on the edge where reset deasserts if reset is still low at that edge.

Structure
REQ-016 A shared package cosim_pkg SHALL hold the entry struct typedef (is_trap, pc, inst, wdata, mstatus, cause, flags, dests) parameterised via localparams, and DROP_CNT_W=16.
REQ-017 Lane compaction SHALL be a sub-module cosim_commit_compactor (per-lane valid + entries in, packed group + n out, purely combinational).

Verification
REQ-018 CW=2, DEPTH=8: valid=2'b10 lane1 pc=0x80000004, out_ready=1 -> next cycle out_valid=1, out_pc=0x80000004, count=1, then 0.
REQ-019 valid=2'b11 (pc 0x100, 0x104) plus int_xcpt=1 cause=0x8000000000000007 in one cycle -> three pops in order 0x100, 0x104, trap with out_cause=0x8000000000000007.
REQ-020 out_ready=0, push 2 entries/cycle for 4 cycles -> count=8; fifth cycle valid=2'b01 -> dropped, overflow=1, drop_count=1, count stays 8.
REQ-021 count=7, out_ready=1, valid=2'b11 -> group dropped (space 1 < 2), count becomes 6, drop_count +1.
REQ-022 Pre-fill to wrap pointer at index 7, push 2 -> entries at 7 and 0 pop in order with correct fields.
REQ-023 Assert reset low with count=5 between edges -> count=0, out_valid=0, overflow=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cosim_pkg.sv
// Shared types for the co-simulation commit serializer: the buffered entry
// layout (default field widths) and the drop counter width.
package cosim_pkg;

  localparam int unsigned XLEN_P      = 64;
  localparam int unsigned INST_BITS_P = 32;
  localparam int unsigned RD_P        = 5;
  localparam int unsigned DROP_CNT_W  = 16;

  typedef struct packed {
    logic                   is_trap;
    logic [XLEN_P-1:0]      pc;
    logic [INST_BITS_P-1:0] inst;
    logic [XLEN_P-1:0]      wdata;
    logic [XLEN_P-1:0]      mstatus;
    logic [XLEN_P-1:0]      cause;
    logic                   check;
    logic                   wdata_valid;
    logic                   insn_writes_back;
    logic [RD_P-1:0]        wdata_dest;
    logic [RD_P-1:0]        insn_wdata_dest;
  } commit_entry_t;

endpackage

// File: rtl/cosim_commit_compactor.sv
// Packs the valid commit lanes (ascending order, no holes) followed by an
// optional trap entry into a dense group, and reports the group size.
module cosim_commit_compactor
  import cosim_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned N_W          = $clog2(COMMIT_WIDTH + 2)
) (
  input  logic [COMMIT_WIDTH-1:0] lane_valid_i,
  input  commit_entry_t           lane_entry_i [COMMIT_WIDTH],
  input  logic                    trap_valid_i,
  input  commit_entry_t           trap_entry_i,
  output commit_entry_t           group_o [COMMIT_WIDTH+1],
  output logic [N_W-1:0]          n_o
);

  // Running slot index: each valid lane lands in the next free slot
  always_comb begin
    group_o = '{default: '0};
    n_o     = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (lane_valid_i[i]) begin
        group_o[n_o] = lane_entry_i[i];
        n_o          = n_o + N_W'(1);
      end else begin
        n_o = n_o;
      end
    end
    if (trap_valid_i) begin
      group_o[n_o] = trap_entry_i;
      n_o          = n_o + N_W'(1);
    end else begin
      n_o = n_o;
    end
  end

endmodule

// File: rtl/cosim_commit_serializer.sv
// Serializes up to COMMIT_WIDTH commits plus one trap per cycle into a
// one-entry-per-cycle stream; whole groups are dropped when space is short.
module cosim_commit_serializer
  import cosim_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned XLEN         = XLEN_P,
  parameter int unsigned INST_BITS    = INST_BITS_P,
  parameter int unsigned RD           = RD_P,
  parameter int unsigned HARTID_LEN   = 1,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [HARTID_LEN-1:0]         hartid,
  input  logic [COMMIT_WIDTH-1:0]       valid,
  input  logic [COMMIT_WIDTH-1:0]       check,
  input  logic [COMMIT_WIDTH-1:0]       wdata_valid,
  input  logic [COMMIT_WIDTH-1:0]       insn_writes_back,
  input  logic [XLEN*COMMIT_WIDTH-1:0]  pc,
  input  logic [XLEN*COMMIT_WIDTH-1:0]  wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0]  mstatus,
  input  logic [INST_BITS*COMMIT_WIDTH-1:0] inst,
  input  logic [RD*COMMIT_WIDTH-1:0]    wdata_dest,
  input  logic [RD*COMMIT_WIDTH-1:0]    insn_wdata_dest,
  input  logic                          int_xcpt,
  input  logic [XLEN-1:0]               cause,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_is_trap,
  output logic [XLEN-1:0]               out_pc,
  output logic [XLEN-1:0]               out_wdata,
  output logic [XLEN-1:0]               out_mstatus,
  output logic [XLEN-1:0]               out_cause,
  output logic [INST_BITS-1:0]          out_inst,
  output logic [RD-1:0]                 out_wdata_dest,
  output logic [RD-1:0]                 out_insn_wdata_dest,
  output logic                          out_check,
  output logic                          out_wdata_valid,
  output logic                          out_insn_writes_back,
  output logic [HARTID_LEN-1:0]         out_hartid,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          overflow,
  output logic [DROP_CNT_W-1:0]         drop_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned N_W   = $clog2(COMMIT_WIDTH + 2);

  commit_entry_t           lane_entry_s [COMMIT_WIDTH];
  commit_entry_t           trap_entry_s;
  commit_entry_t           group_s [COMMIT_WIDTH+1];
  commit_entry_t           mem_q [DEPTH];
  commit_entry_t           head_s;
  logic [N_W-1:0]          n_s;
  logic [CNT_W-1:0]        space_s;
  logic                    accept_s;
  logic                    pop_s;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  // Slice the flat per-lane buses into entries; traps carry only the cause
  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_entry_s[i]                  = '0;
      lane_entry_s[i].pc               = pc[i*XLEN +: XLEN];
      lane_entry_s[i].inst             = inst[i*INST_BITS +: INST_BITS];
      lane_entry_s[i].wdata            = wdata[i*XLEN +: XLEN];
      lane_entry_s[i].mstatus          = mstatus[i*XLEN +: XLEN];
      lane_entry_s[i].check            = check[i];
      lane_entry_s[i].wdata_valid      = wdata_valid[i];
      lane_entry_s[i].insn_writes_back = insn_writes_back[i];
      lane_entry_s[i].wdata_dest       = wdata_dest[i*RD +: RD];
      lane_entry_s[i].insn_wdata_dest  = insn_wdata_dest[i*RD +: RD];
    end
    trap_entry_s         = '0;
    trap_entry_s.is_trap = 1'b1;
    trap_entry_s.cause   = cause;
  end

  cosim_commit_compactor #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .N_W          (N_W)
  ) u_compactor (
    .lane_valid_i (valid),
    .lane_entry_i (lane_entry_s),
    .trap_valid_i (int_xcpt),
    .trap_entry_i (trap_entry_s),
    .group_o      (group_s),
    .n_o          (n_s)
  );

  // Space is judged on pre-edge occupancy; a same-cycle pop does not help
  always_comb begin
    space_s    = CNT_W'(DEPTH) - count_q;
    accept_s   = (n_s != '0) && (CNT_W'(n_s) <= space_s);
    pop_s      = (count_q != '0) && out_ready;
    wr_ptr_d   = accept_s ? (wr_ptr_q + PTR_W'(n_s)) : wr_ptr_q;
    rd_ptr_d   = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d    = count_q + (accept_s ? CNT_W'(n_s) : CNT_W'(0)) - (pop_s ? CNT_W'(1) : CNT_W'(0));
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if ((n_s != '0) && !accept_s) begin
      overflow_d = 1'b1;
      drop_cnt_d = (drop_cnt_q == {DROP_CNT_W{1'b1}}) ? drop_cnt_q : drop_cnt_q + DROP_CNT_W'(1);
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry storage; slot k of an accepted group goes to wr_ptr+k modulo DEPTH
  always_ff @(posedge clock) begin
    for (int k = 0; k <= COMMIT_WIDTH; k++) begin
      if (accept_s && (N_W'(k) < n_s)) begin
        mem_q[wr_ptr_q + PTR_W'(k)] <= group_s[k];
      end
    end
  end

  assign head_s               = mem_q[rd_ptr_q];
  assign out_valid            = (count_q != '0);
  assign out_is_trap          = head_s.is_trap;
  assign out_pc               = head_s.pc;
  assign out_inst             = head_s.inst;
  assign out_wdata            = head_s.wdata;
  assign out_mstatus          = head_s.mstatus;
  assign out_cause            = head_s.cause;
  assign out_check            = head_s.check;
  assign out_wdata_valid      = head_s.wdata_valid;
  assign out_insn_writes_back = head_s.insn_writes_back;
  assign out_wdata_dest       = head_s.wdata_dest;
  assign out_insn_wdata_dest  = head_s.insn_wdata_dest;
  assign out_hartid           = hartid;
  assign count                = count_q;
  assign overflow             = overflow_q;
  assign drop_count           = drop_cnt_q;

endmodule

// File: tb/tb_cosim_commit_serializer.sv
// Directed bench for cosim_commit_serializer with hand-computed expectations.
module tb_cosim_commit_serializer;

  logic         clock, reset;
  logic [0:0]   hartid;
  logic [1:0]   valid, check, wdata_valid, insn_writes_back;
  logic [127:0] pc, wdata, mstatus;
  logic [63:0]  inst;
  logic [9:0]   wdata_dest, insn_wdata_dest;
  logic         int_xcpt;
  logic [63:0]  cause;
  logic         out_valid, out_ready, out_is_trap;
  logic [63:0]  out_pc, out_wdata, out_mstatus, out_cause;
  logic [31:0]  out_inst;
  logic [4:0]   out_wdata_dest, out_insn_wdata_dest;
  logic         out_check, out_wdata_valid, out_insn_writes_back;
  logic [0:0]   out_hartid;
  logic [3:0]   count;
  logic         overflow;
  logic [15:0]  drop_count;

  int n_assert = 0;
  int n_fail   = 0;

  cosim_commit_serializer dut (
    .clock(clock), .reset(reset), .hartid(hartid),
    .valid(valid), .check(check), .wdata_valid(wdata_valid),
    .insn_writes_back(insn_writes_back), .pc(pc), .wdata(wdata),
    .mstatus(mstatus), .inst(inst), .wdata_dest(wdata_dest),
    .insn_wdata_dest(insn_wdata_dest), .int_xcpt(int_xcpt), .cause(cause),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_trap(out_is_trap),
    .out_pc(out_pc), .out_wdata(out_wdata), .out_mstatus(out_mstatus),
    .out_cause(out_cause), .out_inst(out_inst), .out_wdata_dest(out_wdata_dest),
    .out_insn_wdata_dest(out_insn_wdata_dest), .out_check(out_check),
    .out_wdata_valid(out_wdata_valid), .out_insn_writes_back(out_insn_writes_back),
    .out_hartid(out_hartid), .count(count), .overflow(overflow),
    .drop_count(drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    valid = 2'b00; check = 2'b00; wdata_valid = 2'b00; insn_writes_back = 2'b00;
    pc = '0; wdata = '0; mstatus = '0; inst = '0;
    wdata_dest = '0; insn_wdata_dest = '0; int_xcpt = 1'b0; cause = '0;
  endtask

  initial begin
    reset = 1'b0; hartid = 1'b1; out_ready = 1'b0;
    clear_inputs();
    #3;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_drop_count", 64'(drop_count), 64'd0);
    step(); step();
    reset = 1'b1;

    // Single commit on lane 1 into empty buffer
    valid = 2'b10; pc = {64'h8000_0004, 64'h0}; inst = {32'h00a0_0093, 32'h0}; out_ready = 1'b1;
    step();
    clear_inputs();
    chk("single_out_valid", 64'(out_valid), 64'd1);
    chk("single_out_pc", out_pc, 64'h8000_0004);
    chk("single_out_inst", 64'(out_inst), 64'h00a0_0093);
    chk("single_is_trap", 64'(out_is_trap), 64'd0);
    chk("single_count", 64'(count), 64'd1);
    chk("hartid_fwd", 64'(out_hartid), 64'd1);
    step();
    chk("single_drained_count", 64'(count), 64'd0);
    chk("single_drained_valid", 64'(out_valid), 64'd0);

    // Two commits plus a trap in one cycle
    out_ready = 1'b0;
    valid = 2'b11; pc = {64'h104, 64'h100}; int_xcpt = 1'b1; cause = 64'h8000_0000_0000_0007;
    step();
    clear_inputs();
    chk("grp_count", 64'(count), 64'd3);
    chk("grp_pop0_pc", out_pc, 64'h100);
    chk("grp_pop0_cause", out_cause, 64'h0);
    out_ready = 1'b1;
    step();
    chk("grp_pop1_pc", out_pc, 64'h104);
    chk("grp_pop1_is_trap", 64'(out_is_trap), 64'd0);
    step();
    chk("grp_trap_is_trap", 64'(out_is_trap), 64'd1);
    chk("grp_trap_cause", out_cause, 64'h8000_0000_0000_0007);
    chk("grp_trap_pc", out_pc, 64'h0);
    chk("grp_trap_count", 64'(count), 64'd1);
    step();
    chk("grp_drained_count", 64'(count), 64'd0);

    // Fill to DEPTH, then an overflowing group
    out_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      valid = 2'b11;
      pc = {64'h204 + 64'(8 * g), 64'h200 + 64'(8 * g)};
      step();
    end
    valid = 2'b01; pc = {64'h0, 64'h300};
    step();
    clear_inputs();
    chk("full_count", 64'(count), 64'd8);
    chk("full_overflow", 64'(overflow), 64'd1);
    chk("full_drop_count", 64'(drop_count), 64'd1);
    chk("full_head_stable", out_pc, 64'h200);

    // count=7 with pop: a two-entry group still does not fit
    out_ready = 1'b1;
    step();
    chk("seven_count", 64'(count), 64'd7);
    chk("seven_head", out_pc, 64'h204);
    valid = 2'b11; pc = {64'h404, 64'h400};
    step();
    clear_inputs();
    chk("nofit_count", 64'(count), 64'd6);
    chk("nofit_drop_count", 64'(drop_count), 64'd2);
    for (int i = 0; i < 6; i++) begin
      chk("drain_order_pc", out_pc, 64'h208 + 64'(4 * i));
      step();
    end
    chk("drain_count", 64'(count), 64'd0);

    // Advance write pointer to 7, then push a group straddling the wrap
    valid = 2'b11; pc = {64'h604, 64'h600};
    step();
    valid = 2'b01; pc = {64'h0, 64'h608};
    step();
    clear_inputs();
    step(); step();
    chk("prewrap_count", 64'(count), 64'd0);
    out_ready = 1'b0;
    valid = 2'b11; pc = {64'h404, 64'h400}; inst = {32'h00b0_0113, 32'h00c0_0193};
    wdata = {64'hbbbb, 64'haaaa}; mstatus = {64'h1800, 64'h0a00};
    wdata_dest = {5'd2, 5'd3}; insn_wdata_dest = {5'd4, 5'd5};
    check = 2'b10; wdata_valid = 2'b01; insn_writes_back = 2'b11;
    step();
    clear_inputs();
    chk("wrap_count", 64'(count), 64'd2);
    chk("wrap7_pc", out_pc, 64'h400);
    chk("wrap7_inst", 64'(out_inst), 64'h00c0_0193);
    chk("wrap7_wdata", out_wdata, 64'haaaa);
    chk("wrap7_mstatus", out_mstatus, 64'h0a00);
    chk("wrap7_wdest", 64'(out_wdata_dest), 64'd3);
    chk("wrap7_iwdest", 64'(out_insn_wdata_dest), 64'd5);
    chk("wrap7_check", 64'(out_check), 64'd0);
    chk("wrap7_wvalid", 64'(out_wdata_valid), 64'd1);
    chk("wrap7_iwb", 64'(out_insn_writes_back), 64'd1);
    out_ready = 1'b1;
    step();
    chk("wrap0_pc", out_pc, 64'h404);
    chk("wrap0_inst", 64'(out_inst), 64'h00b0_0113);
    chk("wrap0_wdata", out_wdata, 64'hbbbb);
    chk("wrap0_mstatus", out_mstatus, 64'h1800);
    chk("wrap0_wdest", 64'(out_wdata_dest), 64'd2);
    chk("wrap0_iwdest", 64'(out_insn_wdata_dest), 64'd4);
    chk("wrap0_check", 64'(out_check), 64'd1);
    chk("wrap0_wvalid", 64'(out_wdata_valid), 64'd0);
    step();
    chk("wrap_drained_count", 64'(count), 64'd0);

    // Asynchronous reset mid-operation with five entries buffered
    out_ready = 1'b0;
    valid = 2'b11; pc = {64'h704, 64'h700};
    step(); step();
    valid = 2'b01;
    step();
    clear_inputs();
    chk("prereset_count", 64'(count), 64'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_overflow", 64'(overflow), 64'd0);
    chk("async_rst_drop_count", 64'(drop_count), 64'd0);
    valid = 2'b11; pc = {64'h804, 64'h800};
    step();
    chk("held_rst_count", 64'(count), 64'd0);
    reset = 1'b1;
    clear_inputs();
    valid = 2'b01; pc = {64'h0, 64'h500}; out_ready = 1'b1;
    step();
    clear_inputs();
    chk("post_rst_out_valid", 64'(out_valid), 64'd1);
    chk("post_rst_pc", out_pc, 64'h500);
    step();
    chk("post_rst_count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
